// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter and strobe sequencer for an
// external asynchronous SRAM. Each access runs IDLE -> SETUP -> STROBE -> HOLD,
// and every output is a register that is loaded on the edge entering the state
// it belongs to.
module sram_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        grant,
  output logic [ADDR_W-1:0] sram_adr,
  output logic [DATA_W-1:0] sram_dat_out,
  output logic              sram_dat_oe,
  input  logic [DATA_W-1:0] sram_dat_in,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_cs_n
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  // Index of the requester granted most recently; it loses the next tie.
  logic              last_grant;
  logic              last_grant_next;
  // Latched direction and owner of the access in flight.
  logic              acc_we;
  logic              acc_we_next;
  logic              acc_sel;
  logic              acc_sel_next;

  logic              ack0_next;
  logic              ack1_next;
  logic [DATA_W-1:0] rdata_next;
  logic [1:0]        grant_next;
  logic [ADDR_W-1:0] adr_next;
  logic [DATA_W-1:0] dat_out_next;
  logic              dat_oe_next;
  logic              oe_n_next;
  logic              we_n_next;
  logic              cs_n_next;
  logic              win;

  // Round-robin pick: a lone request wins outright; on a tie the requester
  // that was not granted last time wins.
  function automatic logic pick_winner(input logic r0, input logic r1,
                                       input logic last);
    if (r0 && r1) begin
      return ~last;
    end
    return r1;
  endfunction

  assign win = pick_winner(req0, req1, last_grant);

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    last_grant_next = last_grant;
    acc_we_next     = acc_we;
    acc_sel_next    = acc_sel;
    ack0_next       = 1'b0;
    ack1_next       = 1'b0;
    rdata_next      = rdata;
    grant_next      = grant;
    adr_next        = sram_adr;
    dat_out_next    = sram_dat_out;
    dat_oe_next     = sram_dat_oe;
    oe_n_next       = sram_oe_n;
    we_n_next       = sram_we_n;
    cs_n_next       = sram_cs_n;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // Latch the winner's request; the pins then carry it unchanged
          // for the whole access regardless of the requester's inputs.
          last_grant_next = win;
          acc_sel_next    = win;
          acc_we_next     = win ? we1 : we0;
          grant_next      = win ? 2'b10 : 2'b01;
          adr_next        = win ? addr1 : addr0;
          cs_n_next       = 1'b0;
          if (win ? we1 : we0) begin
            dat_oe_next  = 1'b1;
            dat_out_next = win ? wdata1 : wdata0;
          end else begin
            oe_n_next = 1'b0;
          end
          state_next = SETUP;
        end
      end

      SETUP: begin
        cnt_next = 4'(WAIT_CYCLES - 1);
        if (acc_we) begin
          we_n_next = 1'b0;
        end
        state_next = STROBE;
      end

      STROBE: begin
        if (cnt == 4'd0) begin
          // Last strobe cycle: release WE/OE, sample read data, raise ack.
          we_n_next = 1'b1;
          if (!acc_we) begin
            oe_n_next  = 1'b1;
            rdata_next = sram_dat_in;
          end
          ack0_next  = ~acc_sel;
          ack1_next  = acc_sel;
          state_next = HOLD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end

      HOLD: begin
        // Write data and CS were held one cycle past WE rising; drop now.
        cs_n_next   = 1'b1;
        dat_oe_next = 1'b0;
        grant_next  = 2'b00;
        state_next  = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state, arbitration history and latched access attributes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      acc_we     <= 1'b0;
      acc_sel    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      last_grant <= last_grant_next;
      acc_we     <= acc_we_next;
      acc_sel    <= acc_sel_next;
    end
  end

  // Registered outputs; reset forces the SRAM bus inactive immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata        <= '0;
      grant        <= 2'b00;
      sram_adr     <= '0;
      sram_dat_out <= '0;
      sram_dat_oe  <= 1'b0;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_cs_n    <= 1'b1;
    end else begin
      ack0         <= ack0_next;
      ack1         <= ack1_next;
      rdata        <= rdata_next;
      grant        <= grant_next;
      sram_adr     <= adr_next;
      sram_dat_out <= dat_out_next;
      sram_dat_oe  <= dat_oe_next;
      sram_oe_n    <= oe_n_next;
      sram_we_n    <= we_n_next;
      sram_cs_n    <= cs_n_next;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with a 16-word SRAM model.
module tb_sram_arbiter;

  localparam int WA = 2;

  logic        clk;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [18:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic [1:0]  grant;
  logic [18:0] adr;
  logic [15:0] dat_out;
  logic        dat_oe;
  logic [15:0] dat_in;
  logic        oe_n, we_n, cs_n;

  logic        b_req0, b_we0, b_req1, b_we1;
  logic [18:0] b_addr0, b_addr1;
  logic [15:0] b_wdata0, b_wdata1;
  logic        b_ack0, b_ack1;
  logic [15:0] b_rdata;
  logic [1:0]  b_grant;
  logic [18:0] b_adr;
  logic [15:0] b_dat_out;
  logic        b_dat_oe;
  logic [15:0] b_dat_in;
  logic        b_oe_n, b_we_n, b_cs_n;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [16] = '{default: 16'h0000};
  logic [15:0] last_rd;

  typedef struct {
    logic        sel;
    logic        we;
    logic [18:0] addr;
    logic [15:0] wdata;
    logic        drop;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  sram_arbiter #(.ADDR_W(19), .DATA_W(16), .WAIT_CYCLES(WA)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .grant(grant),
    .sram_adr(adr), .sram_dat_out(dat_out), .sram_dat_oe(dat_oe),
    .sram_dat_in(dat_in),
    .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_cs_n(cs_n)
  );

  sram_arbiter #(.ADDR_W(19), .DATA_W(16), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1),
    .rdata(b_rdata), .grant(b_grant),
    .sram_adr(b_adr), .sram_dat_out(b_dat_out), .sram_dat_oe(b_dat_oe),
    .sram_dat_in(b_dat_in),
    .sram_oe_n(b_oe_n), .sram_we_n(b_we_n), .sram_cs_n(b_cs_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: write while CS and WE are low, read data driven while OE is low.
  always @(posedge clk) begin
    if (!cs_n && !we_n) mem[adr[3:0]] <= dat_out;
  end
  assign dat_in = !oe_n ? mem[adr[3:0]] : 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus protocol invariants, both instances, every cycle.
  always @(negedge clk) begin
    chk("we_oe_both_low", 32'(!we_n && !oe_n), 0);
    chk("dat_oe_while_oe_low", 32'(dat_oe && !oe_n), 0);
    chk("w1_we_oe_both_low", 32'(!b_we_n && !b_oe_n), 0);
    chk("w1_dat_oe_while_oe_low", 32'(b_dat_oe && !b_oe_n), 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One access through the default instance; entered and left at the
  // falling edge of an IDLE cycle.
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, "_idle_grant"}, 32'(grant), 0);
    chk({t, "_idle_cs_n"}, 32'(cs_n), 1);
    if (v.sel) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    @(posedge clk);
    #1;
    if (v.drop) begin
      req0 = 1'b0; req1 = 1'b0;
    end
    @(negedge clk);
    chk({t, "_setup_grant"}, 32'(grant), v.sel ? 2 : 1);
    chk({t, "_setup_cs_n"}, 32'(cs_n), 0);
    chk({t, "_setup_adr"}, 32'(adr), 32'(v.addr));
    chk({t, "_setup_we_n"}, 32'(we_n), 1);
    chk({t, "_setup_oe_n"}, 32'(oe_n), 32'(v.we));
    chk({t, "_setup_dat_oe"}, 32'(dat_oe), 32'(v.we));
    if (v.we) chk({t, "_setup_dat_out"}, 32'(dat_out), 32'(v.wdata));
    chk({t, "_setup_ack"}, 32'({ack0, ack1}), 0);
    for (int k = 0; k < WA; k++) begin
      @(negedge clk);
      chk({t, "_strobe_we_n"}, 32'(we_n), 32'(!v.we));
      chk({t, "_strobe_oe_n"}, 32'(oe_n), 32'(v.we));
      chk({t, "_strobe_cs_n"}, 32'(cs_n), 0);
      chk({t, "_strobe_ack"}, 32'({ack0, ack1}), 0);
    end
    @(negedge clk);
    if (!v.we) last_rd = v.exp_rd;
    chk({t, "_hold_ack0"}, 32'(ack0), 32'(!v.sel));
    chk({t, "_hold_ack1"}, 32'(ack1), 32'(v.sel));
    chk({t, "_hold_we_n"}, 32'(we_n), 1);
    chk({t, "_hold_oe_n"}, 32'(oe_n), 1);
    chk({t, "_hold_cs_n"}, 32'(cs_n), 0);
    chk({t, "_hold_dat_oe"}, 32'(dat_oe), 32'(v.we));
    chk({t, "_hold_adr"}, 32'(adr), 32'(v.addr));
    if (v.we) chk({t, "_hold_dat_out"}, 32'(dat_out), 32'(v.wdata));
    chk({t, "_hold_rdata"}, 32'(rdata), 32'(last_rd));
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk({t, "_end_grant"}, 32'(grant), 0);
    chk({t, "_end_cs_n"}, 32'(cs_n), 1);
    chk({t, "_end_dat_oe"}, 32'(dat_oe), 0);
    chk({t, "_end_ack"}, 32'({ack0, ack1}), 0);
    chk({t, "_end_rdata"}, 32'(rdata), 32'(last_rd));
  endtask

  initial begin
    int na;
    int prev_g;
    logic [1:0] g_seq [4];
    int ng;
    int ack_cyc [4];
    logic ack_who [4];

    vecs[0] = '{sel: 1'b0, we: 1'b1, addr: 19'h12345, wdata: 16'hBEEF, drop: 1'b0, exp_rd: 16'h0000};
    vecs[1] = '{sel: 1'b0, we: 1'b0, addr: 19'h12345, wdata: 16'h0000, drop: 1'b0, exp_rd: 16'hBEEF};
    vecs[2] = '{sel: 1'b1, we: 1'b1, addr: 19'h000A7, wdata: 16'h1234, drop: 1'b1, exp_rd: 16'h0000};
    vecs[3] = '{sel: 1'b0, we: 1'b0, addr: 19'h000A7, wdata: 16'h0000, drop: 1'b1, exp_rd: 16'h1234};
    vecs[4] = '{sel: 1'b1, we: 1'b0, addr: 19'h7FFFB, wdata: 16'h0000, drop: 1'b0, exp_rd: 16'h0000};
    vecs[5] = '{sel: 1'b1, we: 1'b1, addr: 19'h7FFFF, wdata: 16'hFFFF, drop: 1'b0, exp_rd: 16'h0000};
    vecs[6] = '{sel: 1'b1, we: 1'b0, addr: 19'h7FFFF, wdata: 16'h0000, drop: 1'b1, exp_rd: 16'hFFFF};

    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;
    b_dat_in = 16'h0000;
    last_rd = 16'h0000;

    #12;
    chk("rst_oe_n", 32'(oe_n), 1);
    chk("rst_we_n", 32'(we_n), 1);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_dat_oe", 32'(dat_oe), 0);
    chk("rst_adr", 32'(adr), 0);
    chk("rst_dat_out", 32'(dat_out), 0);
    chk("rst_ack", 32'({ack0, ack1}), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_grant", 32'(grant), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset asserted during the write strobe clears the bus at once.
    req0 = 1'b1; we0 = 1'b1; addr0 = 19'h00009; wdata0 = 16'h1111;
    @(posedge clk);
    #1 req0 = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_we_n", 32'(we_n), 0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we_n", 32'(we_n), 1);
    chk("mid_rst_cs_n", 32'(cs_n), 1);
    chk("mid_rst_dat_oe", 32'(dat_oe), 0);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_adr", 32'(adr), 0);
    chk("mid_rst_rdata", 32'(rdata), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_ack0", 32'(ack0), 0);
    rst = 1'b0;

    // Both requesting reads continuously: strict alternation from requester 0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 19'h00005;
    req1 = 1'b1; we1 = 1'b0; addr1 = 19'h7FFFF;
    na = 0; ng = 0; prev_g = 0;
    for (int c = 0; c < 60 && na < 4; c++) begin
      @(negedge clk);
      if (grant != 2'b00 && prev_g == 0) begin
        if (ng < 4) g_seq[ng] = grant;
        ng++;
      end
      prev_g = int'(grant);
      chk("alt_single_ack", 32'(ack0 && ack1), 0);
      if (ack0 || ack1) begin
        ack_cyc[na] = c;
        ack_who[na] = ack1;
        chk("alt_rdata", 32'(rdata), ack1 ? 32'hFFFF : 32'hBEEF);
        na++;
        if (na == 4) begin
          req0 = 1'b0; req1 = 1'b0;
        end
      end
    end
    chk("alt_ack_count", 32'(na), 4);
    chk("alt_grant_count", 32'(ng), 4);
    for (int i = 0; i < 4 && i < na && i < ng; i++) begin
      chk($sformatf("alt_grant%0d", i), 32'(g_seq[i]), (i % 2) ? 2 : 1);
      chk($sformatf("alt_ack_who%0d", i), 32'(ack_who[i]), 32'(i % 2));
      if (i > 0) chk($sformatf("alt_ack_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 5);
    end

    // Requester 1 alone streams back-to-back writes.
    req1 = 1'b1; we1 = 1'b1; addr1 = 19'h00002; wdata1 = 16'h2222;
    na = 0;
    for (int c = 0; c < 60 && na < 3; c++) begin
      @(negedge clk);
      if (grant != 2'b00) chk("stream_grant", 32'(grant), 2);
      chk("stream_no_ack0", 32'(ack0), 0);
      if (ack1) begin
        ack_cyc[na] = c;
        na++;
        if (na == 3) req1 = 1'b0;
      end
    end
    chk("stream_ack_count", 32'(na), 3);
    for (int i = 1; i < 3 && i < na; i++)
      chk($sformatf("stream_ack_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 5);
    chk("stream_mem", 32'(mem[2]), 32'h2222);

    // One-cycle strobe instance: ack three cycles after the grant decision.
    @(negedge clk);
    b_req0 = 1'b1; b_we0 = 1'b1; b_addr0 = 19'h00003; b_wdata0 = 16'h5A5A;
    @(posedge clk);
    #1 b_req0 = 1'b0;
    @(negedge clk);
    chk("w1_setup_grant", 32'(b_grant), 1);
    chk("w1_setup_cs_n", 32'(b_cs_n), 0);
    chk("w1_setup_we_n", 32'(b_we_n), 1);
    chk("w1_setup_dat_oe", 32'(b_dat_oe), 1);
    chk("w1_setup_ack0", 32'(b_ack0), 0);
    @(negedge clk);
    chk("w1_strobe_we_n", 32'(b_we_n), 0);
    chk("w1_strobe_ack0", 32'(b_ack0), 0);
    @(negedge clk);
    chk("w1_hold_we_n", 32'(b_we_n), 1);
    chk("w1_hold_ack0", 32'(b_ack0), 1);
    chk("w1_hold_dat_out", 32'(b_dat_out), 32'h5A5A);
    chk("w1_hold_adr", 32'(b_adr), 32'h00003);
    @(negedge clk);
    chk("w1_end_grant", 32'(b_grant), 0);
    chk("w1_end_ack0", 32'(b_ack0), 0);
    chk("w1_end_cs_n", 32'(b_cs_n), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port round-robin arbiter and cycle sequencer for the board's external asynchronous SRAM (19-bit address, 16-bit data, active-low OE/WE/CS).
- Sits between the chip top-level SRAM pins and two on-chip requesters, e.g. a LED/pattern engine and a UART loader.
- Owns all SRAM strobe timing; requesters see a simple req/ack handshake.
- Bidirectional DAT is split into out/oe/in; the top level builds the tristate buffer.

Parameters:
ADDR_W, 19, SRAM address width
DATA_W, 16, SRAM data width
WAIT_CYCLES, 2, cycles the WE/OE strobe is held active; legal range 1..15

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous reset, active-high
req0  in  1  requester 0 access request
we0  in  1  requester 0: 1 = write, 0 = read
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
ack0  out  1  one-cycle pulse when requester 0 access completes
req1, we1, addr1, wdata1, ack1  as above, for requester 1
rdata  out  DATA_W  read data, shared; valid from the ack cycle of a read
grant  out  2  one-hot owner of the current access, 00 when idle
sram_adr  out  ADDR_W  to ADR pins
sram_dat_out  out  DATA_W  write data to DAT pins
sram_dat_oe  out  1  1 = FPGA drives DAT
sram_dat_in  in  DATA_W  DAT pin input
sram_oe_n, sram_we_n, sram_cs_n  out  1  to RAMOE, RAMWE, RAMCS; active-low

Behaviour:
- Reset values (asynchronous, immediate, including mid-access):
  - sram_oe_n = sram_we_n = sram_cs_n = 1.
  - sram_dat_oe = 0; sram_adr = 0; sram_dat_out = 0.
  - ack0 = ack1 = 0; rdata = 0; grant = 00.
  - FSM = IDLE; last_grant = 1, so requester 0 wins the first tie.
- FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - All strobes inactive; sram_dat_oe = 0.
  - If any req is high, select a winner, latch its we/addr/wdata into internal registers, set grant, and go to SETUP.
  - Latched values are used for the whole access; requester input changes after the grant cycle are ignored.
- Arbitration:
  - Only one req high: grant it.
  - Both high: grant the requester that is not last_grant.
  - last_grant updates at grant time.
- SETUP (1 cycle): sram_adr = latched addr; sram_cs_n = 0.
  - Write: sram_dat_oe = 1, sram_dat_out = wdata.
  - Read: sram_oe_n = 0.
- STROBE (WAIT_CYCLES cycles, down-counter):
  - Write: sram_we_n = 0.
  - Read: sram_oe_n stays 0; rdata captures sram_dat_in on the final STROBE clock edge.
- HOLD (1 cycle):
  - sram_we_n = 1. For a write, sram_cs_n, address and data stay driven, giving data hold after WE rises.
  - For a read, sram_oe_n = 1.
  - The granted ack is high for exactly this cycle.
  - Next state is IDLE, and sram_dat_oe = 0 in that cycle.
- Latency: grant decided in IDLE cycle t; ack at cycle t+2+WAIT_CYCLES; next grant possible at t+3+WAIT_CYCLES.
  - Period per access: 3+WAIT_CYCLES cycles (5 at default).
- sram_we_n and sram_oe_n are never low in the same cycle.
- sram_dat_oe is never 1 while sram_oe_n = 0.
- rdata holds its value until the next read completes; writes do not change it.
- Requester protocol: keep req high until ack. Deasserting req after grant does not abort the access; ack still pulses. Deasserting req before grant means no access.
- A requester holding req continuously, with the other idle, gets back-to-back accesses.
- With both requesting continuously, grants strictly alternate. No starvation: worst-case wait is one access.
- All outputs are registered.

Test Plan:
- Write then read, requester 0 only, default params: addr0=0x12345, wdata0=0xBEEF, we0=1 -> sram_we_n low for exactly 2 cycles with adr=0x12345 and dat_out=0xBEEF; ack0 at t+4. Read, with SRAM model returning 0xBEEF -> rdata=0xBEEF on the ack0 cycle; sram_dat_oe stays 0 throughout.
- Simultaneous reads, req0=req1=1, held continuously -> grant sequence 01,10,01,10; ack0/ack1 alternate every 5 cycles; no two acks in the same cycle.
- Single requester streaming: req1 held for 3 accesses, req0=0 -> three grants to requester 1 with acks 5 cycles apart.
- Reset mid-access: assert rst during STROBE of a write -> in the same cycle, sram_we_n/cs_n=1, sram_dat_oe=0, no ack. After release, the first tie goes to requester 0.
- WAIT_CYCLES=1: write strobe lasts 1 cycle; ack at t+3.
- Protocol checks on every cycle: WE/OE never both low; dat_oe never set while OE is low; req dropped after grant still yields an ack.
